// File: rtl/nvram_pkg.sv
// Shared types and constants for the NVRAM upload path.
package nvram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_CAPTURE = 2'd2
  } nv_state_e;

  localparam logic [3:0] NV_FILL              = 4'hF;
  localparam logic [7:0] OOR_BYTE             = 8'hFF;
  localparam int         DEFAULT_UPLOAD_INDEX = 4;

endpackage

// File: rtl/nvram_quiet_timer.sv
// Dirty flag plus a saturating quiet-time counter; save_pending rises once the
// RAM has been dirty and untouched for QUIET_CYCLES clocks.
module nvram_quiet_timer
#(
  parameter logic [23:0] QUIET_CYCLES = 24'd12000000
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic cpu_we,
  input  logic clear,
  output logic dirty,
  output logic save_pending
);

  localparam int CW = (QUIET_CYCLES == 24'd0) ? 1 : $clog2(int'(QUIET_CYCLES) + 1);
  localparam logic [CW-1:0] QUIET_MAX = CW'(QUIET_CYCLES);

  logic          dirty_q, dirty_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;

  // A CPU write always wins over a completion clear in the same cycle.
  always_comb begin
    dirty_d = dirty_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    if (cpu_we) begin
      dirty_d = 1'b1;
      cnt_d   = '0;
      pend_d  = 1'b0;
    end else if (clear) begin
      dirty_d = 1'b0;
      cnt_d   = '0;
      pend_d  = 1'b0;
    end else if (dirty_q) begin
      if (cnt_q != QUIET_MAX) cnt_d = cnt_q + CW'(1);
      pend_d = (cnt_d == QUIET_MAX);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      dirty_q <= 1'b0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      dirty_q <= dirty_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  assign dirty        = dirty_q;
  assign save_pending = pend_q;

endmodule

// File: rtl/nvram_uploader.sv
// Serves HPS upload reads from the CMOS read port and tracks when a save is due.
//   state      | meaning
//   ST_IDLE    | waiting for an accepted ioctl_rd
//   ST_READ    | ram_addr presented, RAM read in flight
//   ST_CAPTURE | ram_q valid, byte latched onto ioctl_din
module nvram_uploader
  import nvram_pkg::*;
#(
  parameter int          UPLOAD_INDEX = DEFAULT_UPLOAD_INDEX,
  parameter int          NV_AW        = 10,
  parameter logic [23:0] QUIET_CYCLES = 24'd12000000
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             ioctl_upload,
  input  logic             ioctl_rd,
  input  logic [24:0]      ioctl_addr,
  input  logic [15:0]      ioctl_index,
  output logic [7:0]       ioctl_din,
  output logic [NV_AW-1:0] ram_addr,
  input  logic [3:0]       ram_q,
  input  logic             cpu_cmos_we,
  output logic             nvram_dirty,
  output logic             save_pending,
  output logic             upload_done
);

  nv_state_e        state_q, state_d;
  logic [7:0]       din_q, din_d;
  logic [NV_AW-1:0] ram_addr_q, ram_addr_d;
  logic             last_q, last_d;
  logic             active_prev_q, active_prev_d;
  logic             done_q, done_d;

  logic active;
  logic addr_in_range;
  logic upload_fall;
  logic upload_complete;

  assign active          = ioctl_upload && (ioctl_index == 16'(UPLOAD_INDEX));
  assign addr_in_range   = (ioctl_addr[24:NV_AW] == '0);
  assign upload_fall     = active_prev_q && !ioctl_upload;
  assign upload_complete = upload_fall && last_q;

  // ram_addr doubles as the latched request address; out-of-range reads leave it alone.
  always_comb begin
    state_d       = state_q;
    din_d         = din_q;
    ram_addr_d    = ram_addr_q;
    last_d        = last_q;
    active_prev_d = active;
    done_d        = upload_complete;
    case (state_q)
      ST_IDLE: begin
        if (ioctl_rd && active) begin
          if (addr_in_range) begin
            ram_addr_d = ioctl_addr[NV_AW-1:0];
            state_d    = ST_READ;
          end else begin
            din_d = OOR_BYTE;
          end
        end
      end
      ST_READ: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        din_d = {NV_FILL, ram_q};
        if (ram_addr_q == '1) last_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (upload_fall) last_d = 1'b0;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      din_q         <= 8'h00;
      ram_addr_q    <= '0;
      last_q        <= 1'b0;
      active_prev_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      din_q         <= din_d;
      ram_addr_q    <= ram_addr_d;
      last_q        <= last_d;
      active_prev_q <= active_prev_d;
      done_q        <= done_d;
    end
  end

  assign ioctl_din   = din_q;
  assign ram_addr    = ram_addr_q;
  assign upload_done = done_q;

  nvram_quiet_timer #(
    .QUIET_CYCLES(QUIET_CYCLES)
  ) u_quiet_timer (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .cpu_we       (cpu_cmos_we),
    .clear        (upload_complete),
    .dirty        (nvram_dirty),
    .save_pending (save_pending)
  );

endmodule

// File: tb/tb_nvram_uploader.sv
// Directed bench for nvram_uploader with a behavioural CMOS read port.
module tb_nvram_uploader;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [15:0] ioctl_index;
  logic [7:0]  ioctl_din;
  logic [9:0]  ram_addr;
  logic [3:0]  ram_q;
  logic        cpu_cmos_we;
  logic        nvram_dirty;
  logic        save_pending;
  logic        upload_done;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [7:0] exp_din;
  int done_before;

  nvram_uploader #(
    .UPLOAD_INDEX(4),
    .NV_AW(10),
    .QUIET_CYCLES(24'd100)
  ) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .ioctl_upload (ioctl_upload),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_index  (ioctl_index),
    .ioctl_din    (ioctl_din),
    .ram_addr     (ram_addr),
    .ram_q        (ram_q),
    .cpu_cmos_we  (cpu_cmos_we),
    .nvram_dirty  (nvram_dirty),
    .save_pending (save_pending),
    .upload_done  (upload_done)
  );

  always #5 clk_sys = ~clk_sys;

  // CMOS read port: nibble = addr[3:0], one cycle of latency.
  always @(posedge clk_sys) ram_q <= ram_addr[3:0];

  always @(posedge clk_sys) if (upload_done) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk_sys);
  endtask

  // Issues one accepted in-range read and checks the exact 2-cycle latency.
  task automatic do_read(input int addr);
    logic [7:0] want;
    want = {4'hF, 4'(addr)};
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'(addr);
    tick();
    ioctl_rd = 1'b0;
    tick();
    chk("latency_hold", {24'd0, ioctl_din}, {24'd0, exp_din});
    tick();
    chk("read_data", {24'd0, ioctl_din}, {24'd0, want});
    exp_din = want;
    tick();
  endtask

  task automatic upload_range(input int last_addr);
    ioctl_index  = 16'd4;
    ioctl_upload = 1'b1;
    tick();
    for (int a = 0; a <= last_addr; a++) do_read(a);
  endtask

  initial begin
    reset_n      = 1'b0;
    ioctl_upload = 1'b0;
    ioctl_rd     = 1'b0;
    ioctl_addr   = '0;
    ioctl_index  = 16'd4;
    cpu_cmos_we  = 1'b0;
    exp_din      = 8'h00;
    tick(3);
    chk("rst_din", {24'd0, ioctl_din}, 32'h00);
    chk("rst_ram_addr", {22'd0, ram_addr}, 32'd0);
    chk("rst_dirty", {31'd0, nvram_dirty}, 32'd0);
    chk("rst_pending", {31'd0, save_pending}, 32'd0);
    chk("rst_done", {31'd0, upload_done}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Full clean upload.
    done_before = done_cnt;
    upload_range(1023);
    ioctl_upload = 1'b0;
    tick(4);
    chk("full_done_once", 32'(done_cnt - done_before), 32'd1);

    // Out-of-range and wrong-index reads.
    ioctl_upload = 1'b1;
    tick();
    do_read(5);
    ioctl_rd = 1'b1;
    ioctl_addr = 25'd1024;
    tick();
    ioctl_rd = 1'b0;
    chk("oor_din", {24'd0, ioctl_din}, 32'hFF);
    chk("oor_ram_addr", {22'd0, ram_addr}, 32'd5);
    tick(3);
    ioctl_index = 16'd0;
    ioctl_rd = 1'b1;
    ioctl_addr = 25'd3;
    tick();
    ioctl_rd = 1'b0;
    tick(3);
    chk("idx_din_hold", {24'd0, ioctl_din}, 32'hFF);
    chk("idx_ram_addr", {22'd0, ram_addr}, 32'd5);
    exp_din = 8'hFF;
    ioctl_index = 16'd4;
    done_before = done_cnt;
    ioctl_upload = 1'b0;
    tick(4);
    chk("partial_no_done", 32'(done_cnt - done_before), 32'd0);

    // Quiet timer: write, rewrite at cycle 50, pending 100 cycles later.
    cpu_cmos_we = 1'b1;
    tick();
    cpu_cmos_we = 1'b0;
    chk("dirty_set", {31'd0, nvram_dirty}, 32'd1);
    chk("pend_early", {31'd0, save_pending}, 32'd0);
    tick(49);
    cpu_cmos_we = 1'b1;
    tick();
    cpu_cmos_we = 1'b0;
    tick(49);
    chk("pend_old_deadline", {31'd0, save_pending}, 32'd0);
    tick(50);
    chk("pend_minus1", {31'd0, save_pending}, 32'd0);
    tick();
    chk("pend_at_100", {31'd0, save_pending}, 32'd1);
    tick(5);
    chk("pend_saturated", {31'd0, save_pending}, 32'd1);

    // Aborted upload keeps dirty state.
    done_before = done_cnt;
    upload_range(500);
    ioctl_upload = 1'b0;
    tick(4);
    chk("abort_no_done", 32'(done_cnt - done_before), 32'd0);
    chk("abort_dirty", {31'd0, nvram_dirty}, 32'd1);
    chk("abort_pending", {31'd0, save_pending}, 32'd1);

    // Complete upload clears.
    done_before = done_cnt;
    upload_range(1023);
    ioctl_upload = 1'b0;
    tick(4);
    chk("clean_done", 32'(done_cnt - done_before), 32'd1);
    chk("clean_dirty", {31'd0, nvram_dirty}, 32'd0);
    chk("clean_pending", {31'd0, save_pending}, 32'd0);

    // CPU write coincident with completion edge.
    cpu_cmos_we = 1'b1;
    tick();
    cpu_cmos_we = 1'b0;
    upload_range(1023);
    chk("pre_fall_pending", {31'd0, save_pending}, 32'd1);
    ioctl_upload = 1'b0;
    cpu_cmos_we  = 1'b1;
    tick();
    cpu_cmos_we = 1'b0;
    chk("coinc_done", {31'd0, upload_done}, 32'd1);
    chk("coinc_dirty", {31'd0, nvram_dirty}, 32'd1);
    chk("coinc_pending", {31'd0, save_pending}, 32'd0);
    tick();
    chk("coinc_done_pulse", {31'd0, upload_done}, 32'd0);

    // Read strobe during READ is dropped.
    ioctl_upload = 1'b1;
    tick();
    ioctl_rd = 1'b1;
    ioctl_addr = 25'd3;
    tick();
    ioctl_addr = 25'd8;
    tick();
    ioctl_rd = 1'b0;
    tick();
    chk("drop_din", {24'd0, ioctl_din}, 32'hF3);
    chk("drop_ram_addr", {22'd0, ram_addr}, 32'd3);
    tick(2);
    chk("drop_din_stable", {24'd0, ioctl_din}, 32'hF3);
    exp_din = 8'hF3;

    // Reset during CAPTURE.
    ioctl_rd = 1'b1;
    ioctl_addr = 25'd9;
    tick();
    ioctl_rd = 1'b0;
    tick();
    chk("pre_rst_din", {24'd0, ioctl_din}, 32'hF3);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("midrst_din", {24'd0, ioctl_din}, 32'h00);
    chk("midrst_ram_addr", {22'd0, ram_addr}, 32'd0);
    exp_din = 8'h00;
    tick();
    do_read(7);
    ioctl_upload = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nvram_uploader.md
Name: nvram_uploader

Overview:
- Reader end of the HPS ioctl transfer: serves HPS upload (save) requests by reading the Williams 1Kx4 CMOS high-score RAM and returning bytes on ioctl_din.
- Tracks CPU writes to CMOS and reports when a save is worth doing.
- Sits between hps_io and williams2 in the top level, on the second (read-only) port of the CMOS dual-port RAM, in the clk_sys domain.

Parameters:
- UPLOAD_INDEX, 4, ioctl_index value this block answers; other indices are ignored.
- NV_AW, 10, CMOS address width (1024 nibbles).
- QUIET_CYCLES, 24'd12000000, clk_sys cycles with no CPU CMOS write before save_pending rises (1 s at 12 MHz).

Ports:
- clk_sys  in  1  system clock (12 MHz).
- reset_n  in  1  synchronous, active-low reset.
- ioctl_upload  in  1  HPS upload in progress.
- ioctl_rd  in  1  one-cycle read strobe from hps_io.
- ioctl_addr  in  25  byte address of the requested read.
- ioctl_index  in  16  transfer index.
- ioctl_din  out  8  read data returned to hps_io.
- ram_addr  out  NV_AW  CMOS read-port address.
- ram_q  in  4  CMOS read-port data; valid 1 cycle after ram_addr.
- cpu_cmos_we  in  1  CPU write strobe to CMOS, 1 cycle per write.
- nvram_dirty  out  1  CMOS modified since last completed upload.
- save_pending  out  1  dirty and quiet for QUIET_CYCLES.
- upload_done  out  1  1-cycle pulse when a full upload completes.

Behaviour:
- Reset (reset_n=0 at clk edge) forces:
  - state IDLE; ioctl_din=8'h00, ram_addr=0.
  - nvram_dirty=0, save_pending=0, upload_done=0.
  - quiet counter=0, last-address flag cleared.
- Reset mid-upload aborts; the next ioctl_rd is served normally.
- Active set: ioctl_upload=1 and ioctl_index==UPLOAD_INDEX. ioctl_rd outside the active set is ignored; ioctl_din holds its value.
- FSM:
  - IDLE: on active ioctl_rd, latch ioctl_addr.
    - If addr < 2**NV_AW: drive ram_addr=addr[NV_AW-1:0], go to READ.
    - Else: ioctl_din=8'hFF next cycle, stay IDLE; no RAM access.
  - READ (1 cycle): wait for ram_q.
  - CAPTURE (1 cycle): ioctl_din <= {4'hF, ram_q}; if latched addr == 2**NV_AW-1, set the last-address flag; go to IDLE.
- Latency: ioctl_rd in cycle N gives ioctl_din valid at the end of cycle N+2, held stable until the next accepted read.
- ioctl_rd arriving in READ or CAPTURE is a protocol violation: it is dropped and the in-flight read completes. hps_io spaces reads by ≥4 cycles.
- Upload completion: on the falling edge of ioctl_upload (1→0, index matched) with the last-address flag set:
  - upload_done pulses 1 cycle.
  - nvram_dirty and save_pending clear; quiet counter clears.
  - The last-address flag always clears on that falling edge.
  - Falling edge without the flag (aborted upload) clears nothing and gives no pulse.
- Dirty/quiet tracking:
  - cpu_cmos_we sets nvram_dirty, zeroes the quiet counter and clears save_pending.
  - While dirty and no write, the counter increments, saturating at QUIET_CYCLES.
  - save_pending = dirty and counter==QUIET_CYCLES (registered).
  - cpu_cmos_we in the same cycle as the completion edge: write wins. dirty stays 1, counter 0, upload_done still pulses.
- Counter width is clog2(QUIET_CYCLES+1); no wrap.

Decomposition:
- Shared package nvram_pkg holds:
  - FSM state enum (IDLE, READ, CAPTURE).
  - NV_FILL nibble constant 4'hF and OOR_BYTE constant 8'hFF.
  - Default UPLOAD_INDEX.
- One natural sub-module: nvram_quiet_timer (dirty flag, saturating counter, save_pending), reused by future cores with battery RAM.

Test Plan:
- Reset, then upload index 4 reading addr 0..1023 with RAM preloaded with nibble = addr[3:0] → ioctl_din = {4'hF, addr[3:0]} exactly 2 cycles after each rd; upload_done pulses once at upload fall.
- Read at addr 1024 → ioctl_din=8'hFF, ram_addr unchanged; read with ioctl_index=0 → ioctl_din unchanged, no RAM access.
- Single cpu_cmos_we, QUIET_CYCLES=100 → nvram_dirty=1 next cycle, save_pending=1 after 100 idle cycles; a second write at cycle 50 delays save_pending to 100 cycles after that write.
- Upload aborted at addr 500 (upload falls) → no upload_done, nvram_dirty stays 1; a full upload afterwards clears dirty and save_pending.
- cpu_cmos_we coincident with the upload falling edge after addr 1023 → upload_done=1, nvram_dirty=1, save_pending=0.
- reset_n=0 during CAPTURE → next cycle ioctl_din=8'h00, state IDLE; a subsequent rd at addr 7 returns {4'hF, ram[7]} with 2-cycle latency.
